// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_text_pkg
//  Purpose  : Shared types and constants for the VGA text renderer:
//             character cell size, VRAM attribute word layout, RGB444 pixel
//             type, per-pixel pipeline side-band and the 16-colour CGA
//             palette.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vga_text_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    // VRAM word: [15:12] background, [11:8] foreground, [7:0] character code
    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] ch;
    } attr_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Side-band data travelling with each pixel through the fetch pipeline
    typedef struct packed {
        logic       de;
        logic       hit;    // pixel lies in the (valid) cursor cell
        logic       blank;  // outside the 80x30 text area
        logic [3:0] grow;   // glyph row within the cell
        logic [2:0] px;     // pixel column within the cell
    } pix_meta_t;

    // Standard CGA palette, index 0 first
    localparam rgb444_t [0:15] PALETTE = {
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage
`default_nettype wire

// File: rtl/vga_pipe_delay.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pipe_delay
//  Purpose  : Fixed-depth shift register with asynchronous active-high reset
//             to a programmable value. Used to keep sync, DE and per-pixel
//             side-band aligned with the VRAM/font fetch pipeline.
//  Ports    : clk_i  - clock
//             rst_i  - asynchronous reset, active-high
//             d_i    - data in  [WIDTH-1:0]
//             q_o    - data out [WIDTH-1:0], d_i delayed DEPTH cycles
//  Revision : 1.0  initial release
// ============================================================================
module vga_pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_text_renderer
//  Purpose  : 80x30 text-mode pixel generator in the pixel clock domain.
//             Screen coordinate -> VRAM cell fetch -> font row fetch ->
//             palette lookup, with a blinking underline cursor. Fixed
//             4-cycle latency from inputs to RGB/sync/DE, one pixel/cycle.
//  Ports    : clk_pixel, rst_pixel (async, active-high)
//             hsync_in/vsync_in/de_in/frame_in  - from timing generator
//             screen_x/screen_y                 - signed coordinates
//             vram_addr/vram_data               - sync RAM, 1-cycle latency
//             font_addr/font_data               - sync ROM, 1-cycle latency
//             cursor_en/cursor_col/cursor_row   - cursor control
//             hsync_out/vsync_out/de_out        - inputs delayed 4 cycles
//             vga_r/vga_g/vga_b                 - 4:4:4 colour
//  Revision : 1.0  initial release
// ============================================================================
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter int ADDR_WIDTH  = 12,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int BLINK_LOG2  = 5
) (
    input  logic                          clk_pixel,
    input  logic                          rst_pixel,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          de_in,
    input  logic                          frame_in,
    input  logic signed [COORD_WIDTH-1:0] screen_x,
    input  logic signed [COORD_WIDTH-1:0] screen_y,
    output logic        [ADDR_WIDTH-1:0]  vram_addr,
    input  logic        [15:0]            vram_data,
    output logic        [11:0]            font_addr,
    input  logic        [7:0]             font_data,
    input  logic                          cursor_en,
    input  logic        [6:0]             cursor_col,
    input  logic        [4:0]             cursor_row,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          de_out,
    output logic        [3:0]             vga_r,
    output logic        [3:0]             vga_g,
    output logic        [3:0]             vga_b
);

    localparam logic signed [COORD_WIDTH-1:0] c_x_limit = COORD_WIDTH'(COLS * CHAR_W);
    localparam logic signed [COORD_WIDTH-1:0] c_y_limit = COORD_WIDTH'(ROWS * CHAR_H);
    localparam logic [6:0]                    c_cols    = 7'(COLS);
    localparam logic [4:0]                    c_rows    = 5'(ROWS);

    // ------------------------------------------------------------------
    // E1: coordinate -> cell address and pixel side-band
    // ------------------------------------------------------------------
    logic [6:0]            w_col;
    logic [4:0]            w_row;
    logic                  w_blank;
    logic                  w_cursor_valid;
    logic [ADDR_WIDTH-1:0] w_addr;
    pix_meta_t             w_meta;
    logic [ADDR_WIDTH-1:0] vram_addr_q;

    assign w_col = screen_x[9:3];
    assign w_row = screen_y[8:4];

    // Full-width limit checks also catch coordinates that would alias into
    // the text area through the col/row bit slices.
    assign w_blank = screen_x[COORD_WIDTH-1] || (screen_x >= c_x_limit) ||
                     screen_y[COORD_WIDTH-1] || (screen_y >= c_y_limit);

    assign w_cursor_valid = (cursor_col < c_cols) && (cursor_row < c_rows);

    assign w_addr = ADDR_WIDTH'(w_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(w_col);

    always_comb begin
        w_meta       = '0;
        w_meta.de    = de_in;
        w_meta.blank = w_blank;
        w_meta.hit   = w_cursor_valid && (w_col == cursor_col) && (w_row == cursor_row);
        w_meta.grow  = screen_y[3:0];
        w_meta.px    = screen_x[2:0];
    end

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            vram_addr_q <= '0;
        end else begin
            vram_addr_q <= w_blank ? '0 : w_addr;
        end
    end

    assign vram_addr = vram_addr_q;

    // Side-band: E1 + E2 registers give the copy aligned with vram_data,
    // one more register aligns it with font_data.
    pix_meta_t meta_d2;
    pix_meta_t meta_d3;

    vga_pipe_delay #(
        .WIDTH     ($bits(pix_meta_t)),
        .DEPTH     (2),
        .RESET_VAL ('0)
    ) u_meta_d2 (
        .clk_i (clk_pixel),
        .rst_i (rst_pixel),
        .d_i   (w_meta),
        .q_o   (meta_d2)
    );

    vga_pipe_delay #(
        .WIDTH     ($bits(pix_meta_t)),
        .DEPTH     (1),
        .RESET_VAL ('0)
    ) u_meta_d3 (
        .clk_i (clk_pixel),
        .rst_i (rst_pixel),
        .d_i   (meta_d2),
        .q_o   (meta_d3)
    );

    // Syncs come straight off the last stage, reset to the inactive level
    vga_pipe_delay #(
        .WIDTH     (2),
        .DEPTH     (4),
        .RESET_VAL ({~H_POL, ~V_POL})
    ) u_sync_dly (
        .clk_i (clk_pixel),
        .rst_i (rst_pixel),
        .d_i   ({hsync_in, vsync_in}),
        .q_o   ({hsync_out, vsync_out})
    );

    // ------------------------------------------------------------------
    // E2: vram_data valid -> font address, E3: latch colours
    // ------------------------------------------------------------------
    attr_t      w_attr;
    logic [3:0] fg_q;
    logic [3:0] bg_q;

    assign w_attr    = attr_t'(vram_data);
    assign font_addr = {w_attr.ch, meta_d2.grow};

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            fg_q <= '0;
            bg_q <= '0;
        end else begin
            fg_q <= w_attr.fg;
            bg_q <= w_attr.bg;
        end
    end

    // ------------------------------------------------------------------
    // Blink counter
    // ------------------------------------------------------------------
    logic [BLINK_LOG2-1:0] frame_cnt_q;
    logic [BLINK_LOG2-1:0] frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_in) begin
            frame_cnt_d = frame_cnt_q + BLINK_LOG2'(1);
        end
    end

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // E4: glyph bit, cursor underline, palette and output registers
    // ------------------------------------------------------------------
    logic       w_bit;
    logic       w_cursor_on;
    logic [3:0] w_idx;
    rgb444_t    rgb_d;
    rgb444_t    rgb_q;
    logic       de_q;

    always_comb begin
        w_bit       = font_data[3'd7 - meta_d3.px];
        // Underline occupies the bottom two glyph rows of the cursor cell
        w_cursor_on = meta_d3.hit && cursor_en && frame_cnt_q[BLINK_LOG2-1] &&
                      (meta_d3.grow >= 4'd14);
        w_idx       = (w_bit || w_cursor_on) ? fg_q : bg_q;
        rgb_d       = '0;
        if (meta_d3.de && !meta_d3.blank) begin
            rgb_d = PALETTE[w_idx];
        end
    end

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= meta_d3.de;
        end
    end

    assign vga_r  = rgb_q.r;
    assign vga_g  = rgb_q.g;
    assign vga_b  = rgb_q.b;
    assign de_out = de_q;

endmodule
`default_nettype wire
